// File: rtl/aurora_cc_scheduler_pkg.sv
// Shared types and constants for the Aurora clock-compensation scheduler.
package aurora_cc_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PEND,
        CC
    } cc_state_t;

    localparam int unsigned CC_PERIOD_DEFAULT    = 5000;
    localparam int unsigned CC_LENGTH_DEFAULT    = 6;
    localparam int unsigned CC_MAX_DEFER_DEFAULT = 64;
    localparam int unsigned CC_COUNT_SIZE        = 16;

    // K23.7 is the CC character the lane mux drives while cc_active is high.
    localparam logic [7:0] CC_CHAR_K23_7 = 8'hF7;
    localparam logic       CC_CHAR_IS_K  = 1'b1;

endpackage

// File: rtl/aurora_cc_scheduler_if.sv
// AXI-Stream source / data_controller handshake signals seen by the CC scheduler.
interface aurora_cc_scheduler_if;

    logic s_tvalid;
    logic s_tlast;
    logic dc_tready;
    logic s_tready;

    modport master (
        output s_tvalid,
        output s_tlast,
        output dc_tready,
        input  s_tready
    );

    modport slave (
        input  s_tvalid,
        input  s_tlast,
        input  dc_tready,
        output s_tready
    );

endinterface

// File: rtl/aurora_cc_scheduler.sv
// Periodic clock-compensation scheduler with source back-pressure during CC.
// Optional frame alignment of CC starts: define AURORA_CC_FRAME_ALIGN_EN.
module aurora_cc_scheduler
    import aurora_cc_scheduler_pkg::*;
#(
    parameter int unsigned CC_PERIOD = CC_PERIOD_DEFAULT,
    parameter int unsigned CC_LENGTH = CC_LENGTH_DEFAULT,
    parameter int unsigned MAX_DEFER = CC_MAX_DEFER_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     channel_init_finished,
    aurora_cc_scheduler_if.slave     axis,
    output logic                     cc_active,
    output logic                     cc_pending,
    output logic [CC_COUNT_SIZE-1:0] cc_count
);

    localparam int unsigned PW = $clog2(CC_PERIOD);
    localparam int unsigned LW = $clog2(CC_LENGTH + 1);

    cc_state_t               state_q, state_d;
    logic [PW-1:0]           period_q, period_d;
    logic [LW-1:0]           len_q, len_d;
    logic [CC_COUNT_SIZE-1:0] cc_count_q, cc_count_d;
    logic                    cc_active_q, cc_pending_q;
    logic                    period_wrap;
    logic [PW-1:0]           period_next;
    logic                    pend_exit;

    assign axis.s_tready = axis.dc_tready & ~cc_active_q;
    assign cc_active     = cc_active_q;
    assign cc_pending    = cc_pending_q;
    assign cc_count      = cc_count_q;

    assign period_wrap = (period_q == PW'(CC_PERIOD - 1));
    assign period_next = period_wrap ? '0 : period_q + 1'b1;

`ifdef AURORA_CC_FRAME_ALIGN_EN
    localparam int unsigned DW = $clog2(MAX_DEFER + 1);

    logic          in_frame_q, in_frame_d;
    logic [DW-1:0] defer_q, defer_d;
    logic          hs;

    // Exit PEND once the frame has closed (including a tlast beat this cycle)
    // or the deferral budget is spent.
    always_comb begin
        hs         = axis.s_tvalid & axis.s_tready;
        in_frame_d = in_frame_q;
        if (!channel_init_finished) begin
            in_frame_d = 1'b0;
        end else if (hs) begin
            in_frame_d = ~axis.s_tlast;
        end
        defer_d   = (state_q == PEND) ? defer_q + 1'b1 : '0;
        pend_exit = !in_frame_d || (defer_q == DW'(MAX_DEFER - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_q <= 1'b0;
            defer_q    <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            defer_q    <= defer_d;
        end
    end
`else
    localparam int unsigned unused_max_defer = MAX_DEFER;
    logic unused_frame;
    assign unused_frame = axis.s_tvalid ^ axis.s_tlast;
    assign pend_exit    = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        len_d      = len_q;
        cc_count_d = cc_count_q;
        if (!channel_init_finished) begin
            state_d  = IDLE;
            period_d = '0;
            len_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                end
                COUNT: begin
                    period_d = period_next;
                    if (period_wrap) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    period_d = period_next;
                    if (pend_exit) begin
                        state_d = CC;
                        len_d   = '0;
                        if (cc_count_q != '1) begin
                            cc_count_d = cc_count_q + 1'b1;
                        end
                    end
                end
                CC: begin
                    period_d = period_next;
                    len_d    = len_q + 1'b1;
                    if (len_q == LW'(CC_LENGTH - 1)) begin
                        state_d = COUNT;
                        len_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags are registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            len_q        <= '0;
            cc_count_q   <= '0;
            cc_active_q  <= 1'b0;
            cc_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            len_q        <= len_d;
            cc_count_q   <= cc_count_d;
            cc_active_q  <= (state_d == CC);
            cc_pending_q <= (state_d == PEND);
        end
    end

endmodule

// File: doc/aurora_cc_scheduler.md
Name: aurora_cc_scheduler

Overview:
Schedules Aurora clock-compensation (CC) sequences on the TX path once channel initialisation has finished. It runs a start-to-start period counter and raises cc_active for a fixed number of cycles. While cc_active is high, it back-pressures the AXI-Stream source so the lane mux drives CC characters instead of data. It sits between the AXI-Stream source and data_controller, and its cc_active output drives the per-lane CC/data select ahead of the 8b10b encoders.

Parameters:
CC_PERIOD, 5000, cycles from one CC start to the next; legal range CC_PERIOD > CC_LENGTH + MAX_DEFER + 2.
CC_LENGTH, 6, cycles cc_active stays high per sequence; minimum 1.
MAX_DEFER, 64, maximum cycles a pending CC may wait for a frame boundary; used only with AURORA_CC_FRAME_ALIGN_EN.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
channel_init_finished  in  1  level; channel is up
s_tvalid  in  1  AXI-Stream tvalid from source (observed only)
s_tlast  in  1  AXI-Stream tlast from source (observed only)
dc_tready  in  1  ready from data_controller
s_tready  out  1  ready to source = dc_tready & ~cc_active (combinational)
cc_active  out  1  registered; lanes carry CC characters this cycle
cc_pending  out  1  registered; period expired, CC not yet started
cc_count  out  16  number of CC sequences started; saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE, period counter 0, length counter 0, cc_active 0, cc_pending 0, cc_count 0.
- Counter widths: period counter is $clog2(CC_PERIOD) bits; length counter is $clog2(CC_LENGTH+1) bits.
- States: IDLE, COUNT, PEND, CC.
- IDLE: counters held at 0. When channel_init_finished = 1, go to COUNT on the next cycle.
- COUNT: period counter increments every cycle.
  - When the counter equals CC_PERIOD-1, it wraps to 0 and the state goes to PEND.
  - The period counter keeps running in every non-IDLE state, so CC starts are exactly CC_PERIOD apart when there is no deferral.
- PEND: cc_pending = 1.
  - Without the optional feature, PEND lasts exactly one cycle, then the state goes to CC.
  - Net latency is 2 cycles from counter wrap to cc_active = 1.
- CC: cc_active = 1 for exactly CC_LENGTH consecutive cycles, then the state returns to COUNT.
  - cc_count increments on entry to CC.
- Back-pressure: s_tready is forced to 0 while cc_active = 1. Because cc_active is registered, no AXI handshake can occur in any cycle with cc_active = 1.
- Channel drop: if channel_init_finished falls in any state, go to IDLE on the next cycle.
  - cc_active and cc_pending deassert on that same edge; counters clear.
  - cc_count is retained; only rst_n clears it.
- Reset mid-CC: all outputs return to reset values asynchronously. No partial sequence resumes.
- Period expiry during CC: with legal parameters this cannot happen; the bench asserts against it.

Optional Feature:
Macro: AURORA_CC_FRAME_ALIGN_EN.
- Defined:
  - An in_frame flag sets on a handshake (s_tvalid & s_tready) with s_tlast = 0. It clears on a handshake with s_tlast = 1, on channel drop, and on reset.
  - PEND exits to CC on the first cycle in which in_frame = 0 and there is no handshake with s_tlast = 0.
  - PEND also exits when its defer counter reaches MAX_DEFER, which forces CC mid-frame.
  - The defer counter clears on PEND entry. cc_count counts forced and aligned starts alike.
- Undefined: in_frame and the defer logic are absent; PEND is always one cycle.

Decomposition:
- aurora_pkg gains:
  - typedef enum cc_state_t {IDLE, COUNT, PEND, CC}
  - CC_PERIOD_DEFAULT = 5000
  - CC_LENGTH_DEFAULT = 6
  - CC_MAX_DEFER_DEFAULT = 64
  - CC_COUNT_SIZE = 16
  - CC character constant (K23.7) for the lane mux
- No sub-module: the block is a single flat FSM with two counters.

Test Plan:
All scenarios use CC_PERIOD=20, CC_LENGTH=6, MAX_DEFER=8.
1. Reset, then channel_init_finished=1 at cycle 0 with dc_tready=1 held → cc_active high for cycles 22-27 and 42-47; s_tready=0 exactly in those cycles; cc_count=2 at cycle 48.
2. Drop channel_init_finished at the 3rd cycle of a CC → cc_active=0 the next cycle; cc_count unchanged. Re-raise it → first new CC is 22 cycles later.
3. Continuous source traffic (s_tvalid=1) → zero handshakes while cc_active=1; no data loss; ordering preserved at the data_controller side.
4. rst_n pulsed low asynchronously mid-CC → all outputs 0 immediately; cc_count=0.
5. With AURORA_CC_FRAME_ALIGN_EN, a 5-beat frame in progress when the period expires → CC starts the cycle after the tlast handshake; the frame is not split.
6. With AURORA_CC_FRAME_ALIGN_EN, a 30-beat frame in progress → CC is forced after 8 PEND cycles; the frame resumes after 6 CC cycles.
